axi4_frame_reader: RTL and testbench

AXI4_FRAME_READER -- requirements
Module: axi4_frame_reader

---
 rtl/axi4_frame_reader.sv | 168 ++++++++++++++++
 tb/tb_axi4_frame_reader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_frame_reader.sv
// axi4_frame_reader: streams one frame buffer out of AXI4 memory as
// back-to-back INCR read bursts. The words pass through a 32-entry
// first-word-fall-through FIFO and leave on a valid/ready word stream.
// Only one burst is outstanding at a time. A new AR is issued only when
// the FIFO can hold the whole burst, so RREADY never depends on m_ready.
module axi4_frame_reader #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_BEATS    = 16,
  parameter int FRAME_BYTES    = 153600
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  input  logic                      frame_start,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic                      RLAST,
  input  logic [1:0]                RRESP,
  output logic [AXI_DATA_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      frame_busy,
  output logic                      err_sticky
);

  localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_BEATS * BEAT_BYTES;
  localparam int FRAME_WORDS = FRAME_BYTES / BEAT_BYTES;
  localparam int FIFO_DEPTH  = 32;
  localparam int PTR_W       = 5;
  localparam int CNT_W       = 6;
  localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR_SEND, DATA_RECV, FLUSH} state_t;

  state_t                    state, state_nxt;
  logic [1:0]                rst_sync;
  logic                      rst_n;
  logic [AXI_ADDR_WIDTH-1:0] base, pend_base, offset;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [14:0]               word_cnt;

  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;

  logic r_hs, beat_last, burst_done, bursts_left, fifo_room;
  logic outstanding, restart_now, go_flush, flush_end, do_load;
  logic wr_en, pop;
  logic [AXI_ADDR_WIDTH-1:0] load_base;

  // Fixed burst attributes: full-width INCR bursts, normal non-cacheable.
  assign ARLEN   = 8'(BURST_BEATS - 1);
  assign ARSIZE  = 3'b011;
  assign ARBURST = 2'b01;
  assign ARCACHE = 4'b0010;
  assign ARPROT  = 3'b000;

  // Reset asserts asynchronously and releases through two flops.
  always_ff @(posedge clk_100Mhz or negedge rst)
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  assign ARVALID    = (state == ADDR_SEND);
  assign RREADY     = (state == DATA_RECV) || (state == FLUSH);
  assign r_hs       = RVALID && RREADY;
  assign beat_last  = (beat_cnt == BEAT_W'(BURST_BEATS - 1));
  assign burst_done = r_hs && beat_last;
  assign bursts_left = frame_busy && (offset < AXI_ADDR_WIDTH'(FRAME_BYTES));
  assign fifo_room  = (fifo_cnt <= CNT_W'(FIFO_DEPTH - BURST_BEATS));

  // A burst is still owed to us after this edge if the AR handshakes now,
  // or if a data phase is running and does not finish this cycle.
  assign outstanding = ((state == ADDR_SEND) && ARREADY) ||
                       (((state == DATA_RECV) || (state == FLUSH)) && !burst_done);
  assign restart_now = frame_start && !outstanding;
  assign go_flush    = frame_start && outstanding;
  assign flush_end   = (state == FLUSH) && burst_done && !frame_start;
  assign do_load     = restart_now || flush_end;
  assign load_base   = restart_now ? FRAME_BASE_ADDR : pend_base;

  assign wr_en   = r_hs && (state == DATA_RECV);
  assign m_valid = (fifo_cnt != '0) && (state != FLUSH);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (word_cnt == 15'(FRAME_WORDS - 1));

  // State register.
  always_ff @(posedge clk_100Mhz or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next state: the normal burst loop, overridden by a new frame request.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (bursts_left && fifo_room) state_nxt = ADDR_SEND;
      ADDR_SEND: if (ARREADY)    state_nxt = DATA_RECV;
      DATA_RECV: if (burst_done) state_nxt = IDLE;
      FLUSH:     if (burst_done) state_nxt = IDLE;
    endcase
    if (go_flush)         state_nxt = FLUSH;
    else if (frame_start) state_nxt = IDLE;
  end

  // Frame addressing, beat counting and the status flags.
  always_ff @(posedge clk_100Mhz or negedge rst_n)
    if (!rst_n) begin
      ARADDR     <= '0;
      base       <= '0;
      pend_base  <= '0;
      offset     <= '0;
      beat_cnt   <= '0;
      word_cnt   <= '0;
      frame_busy <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_nxt == ADDR_SEND)) ARADDR <= base + offset;
      if ((state == DATA_RECV) && burst_done)
        offset <= offset + AXI_ADDR_WIDTH'(BURST_BYTES);
      if (frame_start) pend_base <= FRAME_BASE_ADDR;
      if (do_load) begin
        base   <= load_base;
        offset <= '0;
      end
      if (r_hs) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      if (frame_start) word_cnt <= '0;
      else if (pop)    word_cnt <= word_cnt + 1'b1;
      if (frame_start)        frame_busy <= 1'b1;
      else if (pop && m_last) frame_busy <= 1'b0;
      // The beat counter, not RLAST, closes a burst; a disagreement is an error.
      if (frame_start) err_sticky <= 1'b0;
      else if (wr_en && ((RRESP != 2'b00) || (RLAST != beat_last))) err_sticky <= 1'b1;
    end

  // FIFO pointers and occupancy; a new frame throws away whatever is queued.
  always_ff @(posedge clk_100Mhz or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (do_load) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CNT_W'(wr_en) - CNT_W'(pop);
    end

  // FIFO storage; contents need no reset because occupancy gates the output.
  always_ff @(posedge clk_100Mhz)
    if (wr_en) mem[wr_ptr] <= RDATA;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Bench for axi4_frame_reader: a randomised AXI read slave serves data
// derived from the address. A scoreboard holds the words each frame_start
// should produce. A monitor pops that scoreboard on every accepted output
// word and checks every AR handshake against the expected burst address.
module tb_axi4_frame_reader;
  localparam int FB     = 4096;
  localparam int W      = FB / 8;
  localparam int BURSTS = FB / 128;

  logic        clk_100Mhz = 1'b0;
  logic        rst, frame_start, ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic        m_valid, m_ready, m_last, frame_busy, err_sticky;
  logic [31:0] FRAME_BASE_ADDR, ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST, RRESP;
  logic [3:0]  ARCACHE;
  logic [63:0] RDATA, m_data;

  axi4_frame_reader #(.FRAME_BYTES(FB)) dut (
    .clk_100Mhz(clk_100Mhz), .rst(rst), .FRAME_BASE_ADDR(FRAME_BASE_ADDR),
    .frame_start(frame_start), .ARADDR(ARADDR), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARCACHE(ARCACHE), .ARPROT(ARPROT), .RDATA(RDATA), .RVALID(RVALID),
    .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_busy(frame_busy), .err_sticky(err_sticky));

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct packed { logic [63:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] arq[$];
  int          checks = 0, errors = 0;
  int          ar_mode = 0, rv_mode = 0, mr_mode = 0;
  int          ar_n = 0, words_popped = 0, sl_done = 0, sl_beat = 0;
  bit          inj_rresp = 0, inj_nolast = 0;

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {a ^ 32'hC3A5_5A3C, (a * 32'h9E37_79B1) ^ 32'h0F0F_F0F0};
  endfunction

  task automatic check(input string nm, input logic ok,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // AXI read slave: randomised ARREADY / RVALID, data derived from address.
  initial begin
    bit          ar_hs, r_hs, nolast_burst;
    logic [31:0] ar_a;
    int          ar_wait;
    ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0; RDATA = '0;
    nolast_burst = 0; ar_wait = 0;
    forever begin
      @(negedge clk_100Mhz); #3;
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      ar_a  = ARADDR;
      if (ARVALID && !ARREADY) ar_wait++;
      @(posedge clk_100Mhz); #1;
      if (!rst) begin
        arq.delete(); sl_beat = 0; RVALID = 0; ARREADY = 0;
        ar_wait = 0; nolast_burst = 0;
        continue;
      end
      if (ar_hs) begin arq.push_back(ar_a); ar_wait = 0; end
      if (r_hs) begin
        if (sl_beat == 15) begin
          sl_beat = 0; void'(arq.pop_front()); sl_done++; nolast_burst = 0;
        end else sl_beat++;
      end
      case (ar_mode)
        0:       ARREADY = 1'($urandom_range(0, 1));
        1:       ARREADY = 1'b1;
        2:       ARREADY = (ar_wait >= 5);
        default: ARREADY = 1'b0;
      endcase
      if (RVALID && !r_hs) begin
        // AXI: a presented beat stays put until accepted
      end else if (arq.size() > 0 && (rv_mode == 1 || $urandom_range(0, 1) == 1)) begin
        if (sl_beat == 0 && inj_nolast && !nolast_burst) begin
          nolast_burst = 1; inj_nolast = 0;
        end
        RVALID = 1;
        RDATA  = word_of(arq[0] + 32'(sl_beat * 8));
        RLAST  = (sl_beat == 15) && !nolast_burst;
        RRESP  = 2'b00;
        if (inj_rresp) begin RRESP = 2'b10; inj_rresp = 0; end
      end else RVALID = 0;
    end
  end

  // Output sink: random, always or never ready.
  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk_100Mhz); #1;
      case (mr_mode)
        0:       m_ready = 1'($urandom_range(0, 1));
        1:       m_ready = 1'b1;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: AR address/stability checks and scoreboard comparison of words.
  initial begin
    logic [31:0] ar_base = 0, prev_addr = 0;
    bit          prev_arv = 0, prev_arr = 0, prev_fs = 0;
    int          ar_run = 0;
    exp_t        e;
    forever begin
      @(negedge clk_100Mhz); #3;
      if (!rst) begin
        exp_q.delete(); prev_arv = 0; prev_arr = 0; prev_fs = 0; ar_run = 0;
        continue;
      end
      if (prev_arv && !prev_arr && !prev_fs)
        check("ar_hold", ARVALID && ARADDR == prev_addr, {31'd0, ARVALID, ARADDR},
              {32'd1, prev_addr});
      ar_run = ARVALID ? ar_run + 1 : 0;
      if (ARVALID && ARREADY) begin
        check("ar_addr", ARADDR == ar_base + 32'(ar_n * 128), ARADDR,
              ar_base + 32'(ar_n * 128));
        check("ar_attr", {ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT} ==
              {8'd15, 3'b011, 2'b01, 4'b0010, 3'b000},
              {ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT},
              {8'd15, 3'b011, 2'b01, 4'b0010, 3'b000});
        if (ar_mode == 2) check("ar_delay_cycles", ar_run == 6, ar_run, 6);
        ar_n++;
        check("ar_count_bound", ar_n <= BURSTS, ar_n, BURSTS);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 1'b0, m_data, 0);
        else begin
          e = exp_q.pop_front();
          check("m_data", m_data == e.data, m_data, e.data);
          check("m_last", m_last == e.last, m_last, e.last);
          words_popped++;
        end
      end
      if (frame_start) begin
        exp_q.delete();
        for (int k = 0; k < W; k++)
          exp_q.push_back('{data: word_of(FRAME_BASE_ADDR + 32'(k * 8)), last: (k == W - 1)});
        ar_base = FRAME_BASE_ADDR; ar_n = 0; words_popped = 0;
      end
      prev_arv = ARVALID; prev_arr = ARREADY; prev_addr = ARADDR; prev_fs = frame_start;
    end
  end

  task automatic start_frame(input logic [31:0] b);
    FRAME_BASE_ADDR = b; frame_start = 1; sl_done = 0;
    @(posedge clk_100Mhz); #1;
    frame_start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    repeat (2) @(posedge clk_100Mhz);
    #2;
    while (frame_busy && n < 20000) begin @(posedge clk_100Mhz); #2; n++; end
    check({nm, "_done"}, !frame_busy, frame_busy, 0);
    check({nm, "_words"}, words_popped == W, words_popped, W);
    check({nm, "_ar_total"}, ar_n == BURSTS, ar_n, BURSTS);
    check({nm, "_sb_empty"}, exp_q.size() == 0, exp_q.size(), 0);
  endtask

  function automatic logic [31:0] rand_base();
    return $urandom & 32'hFFFF_FF80;
  endfunction

  // Directed sequence of frames over the randomised slave and sink.
  initial begin
    int n;
    bit found;
    rst = 1; frame_start = 0; FRAME_BASE_ADDR = 0;
    #1 rst = 0;
    repeat (3) @(posedge clk_100Mhz);
    #2;
    check("rst_arvalid", ARVALID == 0, ARVALID, 0);
    check("rst_rready", RREADY == 0, RREADY, 0);
    check("rst_m_valid", m_valid == 0, m_valid, 0);
    check("rst_m_last", m_last == 0, m_last, 0);
    check("rst_busy", frame_busy == 0, frame_busy, 0);
    check("rst_err", err_sticky == 0, err_sticky, 0);
    @(posedge clk_100Mhz); #1 rst = 1;
    repeat (4) @(posedge clk_100Mhz);
    #1;

    // Frame 1: fixed base, random handshakes everywhere.
    start_frame(32'h0100_0000);
    wait_done("f1");
    check("f1_err", err_sticky == 0, err_sticky, 0);

    // Frame 2: one bad RRESP and one burst without RLAST; next frame back-to-back.
    inj_rresp = 1; inj_nolast = 1;
    start_frame(rand_base());
    n = 0; found = 0;
    while (!found && n < 20000) begin
      @(negedge clk_100Mhz);
      if (m_valid && m_ready && m_last) found = 1; else n++;
    end
    check("f2_last_seen", found, found, 1);
    check("f2_err", err_sticky == 1, err_sticky, 1);
    check("f2_words_before_last", words_popped == W - 1, words_popped, W - 1);
    #1;
    ar_mode = 2; FRAME_BASE_ADDR = rand_base(); frame_start = 1; sl_done = 0;
    @(posedge clk_100Mhz); #1 frame_start = 0;
    #1;
    check("b2b_err_cleared", err_sticky == 0, err_sticky, 0);
    check("b2b_busy", frame_busy == 1, frame_busy, 1);
    wait_done("f3");
    check("f3_err", err_sticky == 0, err_sticky, 0);

    // Frame 4: sink stalled, only two bursts fit the FIFO.
    ar_mode = 0; mr_mode = 2;
    @(posedge clk_100Mhz); #1;
    start_frame(rand_base());
    repeat (300) @(posedge clk_100Mhz);
    #2;
    check("stall_ar_count", ar_n == 2, ar_n, 2);
    check("stall_rready", RREADY == 0, RREADY, 0);
    check("stall_m_valid", m_valid == 1, m_valid, 1);
    mr_mode = 0;
    wait_done("f4");

    // Frame 5: restart in the middle of the third burst.
    ar_mode = 1; rv_mode = 1; mr_mode = 1;
    @(posedge clk_100Mhz); #1;
    start_frame(rand_base());
    n = 0;
    while (!(sl_done == 2 && sl_beat == 7 && RVALID) && n < 2000) begin
      @(posedge clk_100Mhz); #2; n++;
    end
    check("restart_point", n < 2000, n, 2000);
    FRAME_BASE_ADDR = rand_base(); frame_start = 1;
    @(posedge clk_100Mhz); #1 frame_start = 0;
    #1;
    n = 0;
    while (arq.size() > 0 && n < 100) begin
      check("flush_quiet", !m_valid && !ARVALID, {m_valid, ARVALID}, 0);
      @(posedge clk_100Mhz); #2; n++;
    end
    check("flush_bound", n < 100, n, 100);
    wait_done("f5");

    // Frame 6: reset while an AR is waiting and the FIFO holds data.
    ar_mode = 1; rv_mode = 0; mr_mode = 2;
    start_frame(rand_base());
    n = 0;
    while (ar_n < 1 && n < 500) begin @(posedge clk_100Mhz); #2; n++; end
    ar_mode = 3;
    n = 0;
    while (!(ARVALID && m_valid) && n < 500) begin @(posedge clk_100Mhz); #2; n++; end
    check("rst_setup", ARVALID && m_valid, {ARVALID, m_valid}, 2'b11);
    @(posedge clk_100Mhz); #3 rst = 0;
    #1;
    check("async_rst_arvalid", ARVALID == 0, ARVALID, 0);
    check("async_rst_m_valid", m_valid == 0, m_valid, 0);
    check("async_rst_busy", frame_busy == 0, frame_busy, 0);
    check("async_rst_rready", RREADY == 0, RREADY, 0);
    repeat (3) @(posedge clk_100Mhz);
    #1 rst = 1; ar_mode = 0; mr_mode = 0;
    repeat (5) @(posedge clk_100Mhz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
